// File: rtl/id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline register combined with the operand-select / forwarding stage
// that sits directly in front of the ALU. Decoded fields from ID are captured
// each cycle. RAW hazards against the EX/MEM and MEM/WB producers are resolved
// combinationally. Load-use hazards are flagged back to the stall logic.
//
// Configuration macro: EX_FORWARDING_EN
//   defined     : EX/MEM and MEM/WB forwarding onto rs1/rs2. During a stall the
//                 data registers reload with the forwarded value.
//   not defined : operands come straight from the captured register-file data.
//                 The exm_*/wb_* inputs are ignored. The data registers hold
//                 during a stall. load_use_haz also fires for any valid
//                 register-writing producer in EX, not only for loads.
//
// Ports
//   CLK, RST_n              clock (rising edge), asynchronous active-low reset
//   stall, flush            hold / bubble the stage (flush wins)
//   id_*                    decoded instruction fields from ID
//   exm_rd_addr/regwrite/result   EX/MEM producer (forwarding source 1)
//   wb_rd_addr/regwrite/result    MEM/WB producer (forwarding source 2)
//   ALU_operation           registered ALU opcode
//   op1, op2                ALU operands (combinational)
//   store_data              forwarded rs2 value for stores
//   ex_rd_addr, ex_regwrite, ex_memread, ex_valid   registered control for EX/MEM
//   load_use_haz            ID reads a register still being produced by a load in EX
// ----------------------------------------------------------------------------
module id_ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [3:0]      id_alu_op,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [4:0]      id_rd_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_alusrc,
  input  logic [1:0]      id_auipclui,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic [4:0]      exm_rd_addr,
  input  logic            exm_regwrite,
  input  logic [XLEN-1:0] exm_result,
  input  logic [4:0]      wb_rd_addr,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_result,
  output logic [3:0]      ALU_operation,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_valid,
  output logic            load_use_haz
);

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic            valid_q,    valid_d;
  logic [3:0]      alu_op_q,   alu_op_d;
  logic [4:0]      rs1_addr_q, rs1_addr_d;
  logic [4:0]      rs2_addr_q, rs2_addr_d;
  logic [4:0]      rd_addr_q,  rd_addr_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic            alusrc_q,   alusrc_d;
  logic [1:0]      auipclui_q, auipclui_d;
  logic            regwrite_q, regwrite_d;
  logic            memread_q,  memread_d;

  // Forwarded operand values, index 0 = rs1, index 1 = rs2
  logic [XLEN-1:0] rs_data  [2];
  logic [XLEN-1:0] fwd_data [2];

  assign rs_data[0] = rs1_data_q;
  assign rs_data[1] = rs2_data_q;

  // --------------------------------------------------------------------------
  // Forwarding network
  // --------------------------------------------------------------------------
`ifdef EX_FORWARDING_EN
  logic [4:0] rs_addr [2];

  assign rs_addr[0] = rs1_addr_q;
  assign rs_addr[1] = rs2_addr_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic rs_nonzero;
      logic exm_hit;
      logic wb_hit;

      // x0 is hard-wired: a producer that "writes" x0 must never leak through.
      assign rs_nonzero = (rs_addr[gi] != 5'd0);
      assign exm_hit    = exm_regwrite && (exm_rd_addr == rs_addr[gi]) && rs_nonzero;
      assign wb_hit     = wb_regwrite  && (wb_rd_addr  == rs_addr[gi]) && rs_nonzero;

      // EX/MEM holds the younger result, so it takes precedence over MEM/WB.
      assign fwd_data[gi] = exm_hit ? exm_result :
                            (wb_hit ? wb_result : rs_data[gi]);
    end
  endgenerate
`else
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_data[gi] = rs_data[gi];
    end
  endgenerate

  // Producer-side inputs and captured rs indices have no consumer in this build.
  logic unused_fwd;
  assign unused_fwd = ^{exm_rd_addr, exm_regwrite, exm_result,
                        wb_rd_addr,  wb_regwrite,  wb_result,
                        rs1_addr_q,  rs2_addr_q};
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    valid_d    = valid_q;
    alu_op_d   = alu_op_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    alusrc_d   = alusrc_q;
    auipclui_d = auipclui_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;

    if (flush) begin
      // Bubble: only the qualifying control bits matter, the rest may hold.
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
    end else if (stall) begin
`ifdef EX_FORWARDING_EN
      // A MEM/WB result retiring while we sit here would otherwise be gone by
      // the time the stall releases, so absorb the forwarded value now.
      rs1_data_d = fwd_data[0];
      rs2_data_d = fwd_data[1];
`else
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
`endif
    end else begin
      valid_d    = id_valid;
      alu_op_d   = id_alu_op;
      rs1_addr_d = id_rs1_addr;
      rs2_addr_d = id_rs2_addr;
      rd_addr_d  = id_rd_addr;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      pc_d       = id_pc;
      alusrc_d   = id_alusrc;
      auipclui_d = id_auipclui;
      regwrite_d = id_regwrite;
      memread_d  = id_memread;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      valid_q    <= 1'b0;
      alu_op_q   <= 4'b0000;
      rs1_addr_q <= 5'd0;
      rs2_addr_q <= 5'd0;
      rd_addr_q  <= 5'd0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      alusrc_q   <= 1'b0;
      auipclui_q <= 2'b00;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      alu_op_q   <= alu_op_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      alusrc_q   <= alusrc_d;
      auipclui_q <= auipclui_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
    end
  end

  // --------------------------------------------------------------------------
  // Operand select
  // --------------------------------------------------------------------------
  always_comb begin
    op1 = fwd_data[0];
    unique case (auipclui_q)
      2'b01:   op1 = pc_q;       // AUIPC
      2'b10:   op1 = '0;         // LUI
      default: op1 = fwd_data[0];
    endcase
  end

  assign op2        = alusrc_q ? imm_q : fwd_data[1];
  assign store_data = fwd_data[1];

  assign ALU_operation = alu_op_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_valid      = valid_q;

  // --------------------------------------------------------------------------
  // Hazard detection (deliberately not gated by stall/flush: the controller
  // answers this flag with those very signals)
  // --------------------------------------------------------------------------
  logic rs_match;
  logic haz_producer;

  assign rs_match = (rd_addr_q == id_rs1_addr) || (rd_addr_q == id_rs2_addr);

`ifdef EX_FORWARDING_EN
  assign haz_producer = memread_q;
`else
  // Without forwarding any in-flight writer is a hazard, not just loads.
  assign haz_producer = memread_q || regwrite_q;
`endif

  assign load_use_haz = valid_q && haz_producer && (rd_addr_q != 5'd0)
                        && id_valid && rs_match;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// Directed testbench for id_ex_operand_stage. Expected values are hand-derived
// and selected according to whether EX_FORWARDING_EN is defined for the build.
// ----------------------------------------------------------------------------
module tb_id_ex_operand_stage;

`ifdef EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        CLK;
  logic        RST_n;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [3:0]  id_alu_op;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  id_rd_addr;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [31:0] id_pc;
  logic        id_alusrc;
  logic [1:0]  id_auipclui;
  logic        id_regwrite;
  logic        id_memread;
  logic [4:0]  exm_rd_addr;
  logic        exm_regwrite;
  logic [31:0] exm_result;
  logic [4:0]  wb_rd_addr;
  logic        wb_regwrite;
  logic [31:0] wb_result;
  logic [3:0]  ALU_operation;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] store_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_valid;
  logic        load_use_haz;

  int tests_run    = 0;
  int tests_failed = 0;

  id_ex_operand_stage #(.XLEN(32)) dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .stall         (stall),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_alu_op     (id_alu_op),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_rd_addr    (id_rd_addr),
    .id_rs1_data   (id_rs1_data),
    .id_rs2_data   (id_rs2_data),
    .id_imm        (id_imm),
    .id_pc         (id_pc),
    .id_alusrc     (id_alusrc),
    .id_auipclui   (id_auipclui),
    .id_regwrite   (id_regwrite),
    .id_memread    (id_memread),
    .exm_rd_addr   (exm_rd_addr),
    .exm_regwrite  (exm_regwrite),
    .exm_result    (exm_result),
    .wb_rd_addr    (wb_rd_addr),
    .wb_regwrite   (wb_regwrite),
    .wb_result     (wb_result),
    .ALU_operation (ALU_operation),
    .op1           (op1),
    .op2           (op2),
    .store_data    (store_data),
    .ex_rd_addr    (ex_rd_addr),
    .ex_regwrite   (ex_regwrite),
    .ex_memread    (ex_memread),
    .ex_valid      (ex_valid),
    .load_use_haz  (load_use_haz)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Present one instruction on the ID side and let it be captured.
  task automatic load_instr(input logic [3:0] alu, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [31:0] pc, input logic alusrc,
                            input logic [1:0] aul, input logic rw, input logic mr);
    id_valid    = 1'b1;
    id_alu_op   = alu;
    id_rs1_addr = rs1;
    id_rs2_addr = rs2;
    id_rd_addr  = rd;
    id_rs1_data = d1;
    id_rs2_data = d2;
    id_imm      = imm;
    id_pc       = pc;
    id_alusrc   = alusrc;
    id_auipclui = aul;
    id_regwrite = rw;
    id_memread  = mr;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_producers();
    exm_regwrite = 1'b0;
    exm_rd_addr  = 5'd0;
    exm_result   = 32'h0;
    wb_regwrite  = 1'b0;
    wb_rd_addr   = 5'd0;
    wb_result    = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    id_valid = 1'b0; id_alu_op = 4'd0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rd_addr = 5'd0;
    id_rs1_data = 32'h0; id_rs2_data = 32'h0; id_imm = 32'h0; id_pc = 32'h0;
    id_alusrc = 1'b0; id_auipclui = 2'b00; id_regwrite = 1'b0; id_memread = 1'b0;
    clear_producers();
    #2 RST_n = 1'b1;

    // ---- asynchronous reset mid-cycle ----
    load_instr(4'b0110, 5'd1, 5'd2, 5'd3, 32'h10, 32'h20, 32'h5, 32'h40, 1'b1, 2'b01, 1'b1, 1'b1);
    chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    chk("pre_rst_op1", op1, 32'h40);
    #2 RST_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_aluop", {28'd0, ALU_operation}, 32'd0);
    chk("rst_op1", op1, 32'd0);
    chk("rst_op2", op2, 32'd0);
    chk("rst_store", store_data, 32'd0);
    chk("rst_rd", {27'd0, ex_rd_addr}, 32'd0);
    chk("rst_rw_mr", {30'd0, ex_regwrite, ex_memread}, 32'd0);
    RST_n = 1'b1;

    // ---- pass-through: ADDI x3,x1,5 ----
    load_instr(4'b0000, 5'd1, 5'd0, 5'd3, 32'd10, 32'd0, 32'd5, 32'h0, 1'b1, 2'b00, 1'b1, 1'b0);
    chk("addi_aluop", {28'd0, ALU_operation}, 32'd0);
    chk("addi_op1", op1, 32'd10);
    chk("addi_op2", op2, 32'd5);
    chk("addi_rd", {27'd0, ex_rd_addr}, 32'd3);
    chk("addi_valid_rw", {30'd0, ex_valid, ex_regwrite}, 32'd3);

    // ---- XOR register-register ----
    load_instr(4'b0110, 5'd2, 5'd6, 5'd7, 32'h0F, 32'hF0, 32'h999, 32'h0, 1'b0, 2'b11, 1'b1, 1'b0);
    chk("xor_aluop", {28'd0, ALU_operation}, 32'd6);
    chk("xor_op1", op1, 32'h0F);
    chk("xor_op2", op2, 32'hF0);
    chk("xor_store", store_data, 32'hF0);

    // ---- double hazard on rs1 ----
    load_instr(4'b0000, 5'd5, 5'd0, 5'd9, 32'h11, 32'h22, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
    exm_regwrite = 1'b1; exm_rd_addr = 5'd5; exm_result = 32'hAA;
    wb_regwrite  = 1'b1; wb_rd_addr  = 5'd5; wb_result  = 32'hBB;
    #1 chk("dbl_op1", op1, FWD ? 32'hAA : 32'h11);
    exm_regwrite = 1'b0;
    #1 chk("wb_only_op1", op1, FWD ? 32'hBB : 32'h11);
    clear_producers();

    // ---- x0 never forwarded ----
    load_instr(4'b0000, 5'd0, 5'd0, 5'd9, 32'h0, 32'h22, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
    exm_regwrite = 1'b1; exm_rd_addr = 5'd0; exm_result = 32'hAA;
    wb_regwrite  = 1'b1; wb_rd_addr  = 5'd0; wb_result  = 32'hBB;
    #1 chk("x0_op1", op1, 32'h0);
    chk("x0_store", store_data, 32'h22);
    clear_producers();

    // ---- rs2 via MEM/WB, non-matching EX/MEM ----
    load_instr(4'b0000, 5'd1, 5'd8, 5'd9, 32'h1, 32'h33, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
    exm_regwrite = 1'b1; exm_rd_addr = 5'd9; exm_result = 32'hAA;
    wb_regwrite  = 1'b1; wb_rd_addr  = 5'd8; wb_result  = 32'hCC;
    #1 chk("rs2_wb_op2", op2, FWD ? 32'hCC : 32'h33);
    chk("rs2_wb_store", store_data, FWD ? 32'hCC : 32'h33);
    clear_producers();

    // ---- stall retention ----
    load_instr(4'b0000, 5'd1, 5'd7, 5'd10, 32'h1, 32'h1111, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
    stall = 1'b1;
    wb_regwrite = 1'b1; wb_rd_addr = 5'd7; wb_result = 32'h1234;
    id_rs2_addr = 5'd9; id_rs2_data = 32'h9999; id_rd_addr = 5'd11;
    #1 chk("stall_c1_op2", op2, FWD ? 32'h1234 : 32'h1111);
    @(posedge CLK); #1;
    wb_regwrite = 1'b0;
    #1 chk("stall_c2_op2", op2, FWD ? 32'h1234 : 32'h1111);
    chk("stall_c2_rd", {27'd0, ex_rd_addr}, 32'd10);
    @(posedge CLK); #1;
    stall = 1'b0;
    #1 chk("stall_rel_op2", op2, FWD ? 32'h1234 : 32'h1111);
    @(posedge CLK); #1;
    chk("post_stall_op2", op2, 32'h9999);
    chk("post_stall_rd", {27'd0, ex_rd_addr}, 32'd11);
    clear_producers();

    // ---- load-use hazard ----
    load_instr(4'b0000, 5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 1'b1);
    id_rs1_addr = 5'd4; id_rs2_addr = 5'd0;
    #1 chk("lu_rs1", {31'd0, load_use_haz}, 32'd1);
    id_rs1_addr = 5'd2; id_rs2_addr = 5'd4;
    #1 chk("lu_rs2", {31'd0, load_use_haz}, 32'd1);
    id_rs2_addr = 5'd3;
    #1 chk("lu_nomatch", {31'd0, load_use_haz}, 32'd0);
    id_rs1_addr = 5'd4; id_valid = 1'b0;
    #1 chk("lu_id_invalid", {31'd0, load_use_haz}, 32'd0);
    id_valid = 1'b1; flush = 1'b1; stall = 1'b1;
    #1 chk("lu_ungated", {31'd0, load_use_haz}, 32'd1);
    @(posedge CLK); #1;
    flush = 1'b0; stall = 1'b0;
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_rw_mr", {30'd0, ex_regwrite, ex_memread}, 32'd0);
    chk("flush_haz", {31'd0, load_use_haz}, 32'd0);

    // ALU producer: hazard only when there is no forwarding path
    load_instr(4'b0000, 5'd1, 5'd2, 5'd6, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
    id_rs1_addr = 5'd6;
    #1 chk("alu_prod_haz", {31'd0, load_use_haz}, FWD ? 32'd0 : 32'd1);

    // load into x0 is never a hazard
    load_instr(4'b0000, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 1'b1);
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
    #1 chk("lw_x0_haz", {31'd0, load_use_haz}, 32'd0);

    // ---- AUIPC / LUI / rs1 alias ----
    load_instr(4'b0000, 5'd1, 5'd0, 5'd5, 32'h77, 32'h0, 32'h2000, 32'h100, 1'b1, 2'b01, 1'b1, 1'b0);
    chk("auipc_op1", op1, 32'h100);
    chk("auipc_op2", op2, 32'h2000);
    load_instr(4'b0000, 5'd1, 5'd0, 5'd5, 32'h77, 32'h0, 32'h2000, 32'h100, 1'b1, 2'b10, 1'b1, 1'b0);
    chk("lui_op1", op1, 32'h0);
    chk("lui_op2", op2, 32'h2000);
    load_instr(4'b0000, 5'd1, 5'd0, 5'd5, 32'h77, 32'h0, 32'h2000, 32'h100, 1'b1, 2'b11, 1'b1, 1'b0);
    chk("sel11_op1", op1, 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
